// File: rtl/mac_pkg.sv
// Shared definitions for the MAC accumulator slice.
// Holds the FSM state encoding and the default widths.
package mac_pkg;

  localparam int ACC_W_DEF   = 24;
  localparam int MAX_LEN_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/mac_sat_adder.sv
// Combinational extend / add / saturate datapath.
// Ports: acc_i (running sum), product_i (16b), sign_i,
//        sum_o (clamped sum), ovf_o (clamp happened).
module mac_sat_adder
  import mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [15:0]      product_i,
  input  logic             sign_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             ovf_o
);

  logic [ACC_W-1:0] ext;
  logic [ACC_W:0]   raw;

  always_comb begin
    ext = sign_i ? {{(ACC_W-16){product_i[15]}}, product_i}
                 : {{(ACC_W-16){1'b0}}, product_i};
    // One guard bit: for signed it is a sign copy, for
    // unsigned it is the carry out.
    raw = sign_i ? ({acc_i[ACC_W-1], acc_i} + {ext[ACC_W-1], ext})
                 : ({1'b0, acc_i} + {1'b0, ext});
    sum_o = raw[ACC_W-1:0];
    ovf_o = 1'b0;
    if (sign_i) begin
      if (raw[ACC_W] != raw[ACC_W-1]) begin
        ovf_o = 1'b1;
        sum_o = raw[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                           : {1'b0, {(ACC_W-1){1'b1}}};
      end
    end else if (raw[ACC_W]) begin
      ovf_o = 1'b1;
      sum_o = '1;
    end
  end

endmodule

// File: rtl/mac_accumulator.sv
// Saturating dot-product accumulator with valid/ready in and out.
// Ports: Clk, Rst (async high), Product/Sign/In_Valid/In_Last/
//        In_Ready beat input, Clear abort, Result/Overflow/
//        Out_Valid/Out_Ready result output.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEF,
  parameter int MAX_LEN = MAX_LEN_DEF
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [15:0]      Product,
  input  logic             Sign,
  input  logic             In_Valid,
  input  logic             In_Last,
  output logic             In_Ready,
  input  logic             Clear,
  output logic [ACC_W-1:0] Result,
  output logic             Overflow,
  output logic             Out_Valid,
  input  logic             Out_Ready
);

  localparam int CW = $clog2(MAX_LEN + 1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sign_q, sign_d;

  logic             in_ready;
  logic             accept;
  logic             sel_sign;
  logic [ACC_W-1:0] add_acc;
  logic [CW-1:0]    cnt_inc;
  logic             last_beat;
  logic [ACC_W-1:0] sum;
  logic             sum_ovf;

  // First beat adds onto zero so the datapath yields ext(Product)
  // without a separate load path.
  mac_sat_adder #(.ACC_W(ACC_W)) u_add (
    .acc_i     (add_acc),
    .product_i (Product),
    .sign_i    (sel_sign),
    .sum_o     (sum),
    .ovf_o     (sum_ovf)
  );

  always_comb begin
    in_ready  = (state_q != ST_HOLD);
    accept    = In_Valid && in_ready && !Clear;
    sel_sign  = (state_q == ST_IDLE) ? Sign : sign_q;
    add_acc   = (state_q == ST_IDLE) ? '0 : acc_q;
    cnt_inc   = (state_q == ST_IDLE) ? CW'(1) : cnt_q + CW'(1);
    last_beat = In_Last || (cnt_inc == CW'(MAX_LEN));
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    if (Clear) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_ACCUM: begin
          if (accept) begin
            sign_d  = sel_sign;
            acc_d   = sum;
            ovf_d   = ((state_q == ST_ACCUM) && ovf_q) || sum_ovf;
            cnt_d   = cnt_inc;
            state_d = last_beat ? ST_HOLD : ST_ACCUM;
          end
        end
        ST_HOLD: begin
          if (Out_Ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
    end
  end

  assign In_Ready  = in_ready;
  assign Result    = acc_q;
  assign Overflow  = ovf_q;
  assign Out_Valid = (state_q == ST_HOLD);

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator, driving a 24-bit and an
// 18-bit instance with the same beats.
module tb_mac_accumulator;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [15:0] Product;
  logic        Sign;
  logic        In_Valid;
  logic        In_Last;
  logic        Clear;
  logic        Out_Ready;

  logic        rdy24, ov24, ovf24;
  logic [23:0] res24;
  logic        rdy18, ov18, ovf18;
  logic [17:0] res18;

  int n_vec = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  mac_accumulator #(.ACC_W(24), .MAX_LEN(64)) u_dut (
    .Clk(Clk), .Rst(Rst), .Product(Product), .Sign(Sign),
    .In_Valid(In_Valid), .In_Last(In_Last), .In_Ready(rdy24),
    .Clear(Clear), .Result(res24), .Overflow(ovf24),
    .Out_Valid(ov24), .Out_Ready(Out_Ready)
  );

  mac_accumulator #(.ACC_W(18), .MAX_LEN(64)) u_dut18 (
    .Clk(Clk), .Rst(Rst), .Product(Product), .Sign(Sign),
    .In_Valid(In_Valid), .In_Last(In_Last), .In_Ready(rdy18),
    .Clear(Clear), .Result(res18), .Overflow(ovf18),
    .Out_Valid(ov18), .Out_Ready(Out_Ready)
  );

  typedef struct {
    logic [15:0] prod;
    logic        sgn;
    int          n;
    logic [23:0] r24;
    logic        o24;
    logic [17:0] r18;
    logic        o18;
  } vec_t;

  vec_t tbl[9];

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic beat(input logic [15:0] p, input logic s,
                      input logic last);
    Product  = p;
    Sign     = s;
    In_Valid = 1'b1;
    In_Last  = last;
    step();
    In_Valid = 1'b0;
    In_Last  = 1'b0;
  endtask

  task automatic send(input string nm, input logic [15:0] p,
                      input logic s, input int n, input logic last);
    for (int i = 0; i < n; i++) begin
      if (i > 0) chk({nm, "_early_ov"}, 32'(ov24), 32'd0);
      beat(p, s, last && (i == n - 1));
    end
  endtask

  task automatic check_out(input string nm,
                           input logic [23:0] r24, input logic o24,
                           input logic [17:0] r18, input logic o18);
    chk({nm, "_ov24"}, 32'(ov24), 32'd1);
    chk({nm, "_ov18"}, 32'(ov18), 32'd1);
    chk({nm, "_res24"}, 32'(res24), 32'(r24));
    chk({nm, "_ovf24"}, 32'(ovf24), 32'(o24));
    chk({nm, "_res18"}, 32'(res18), 32'(r18));
    chk({nm, "_ovf18"}, 32'(ovf18), 32'(o18));
  endtask

  task automatic drain(input string nm);
    Out_Ready = 1'b1;
    step();
    Out_Ready = 1'b0;
    chk({nm, "_drain_ov"}, 32'(ov24), 32'd0);
    chk({nm, "_drain_rdy"}, 32'(rdy24), 32'd1);
  endtask

  initial begin
    tbl[0] = '{16'hFFFF, 1'b1, 3, 24'hFFFFFD, 1'b0, 18'h3FFFD, 1'b0};
    tbl[1] = '{16'hFFFF, 1'b0, 2, 24'h01FFFE, 1'b0, 18'h1FFFE, 1'b0};
    tbl[2] = '{16'h7FFF, 1'b1, 5, 24'h027FFB, 1'b0, 18'h1FFFF, 1'b1};
    tbl[3] = '{16'h0001, 1'b1, 1, 24'h000001, 1'b0, 18'h00001, 1'b0};
    tbl[4] = '{16'h8000, 1'b1, 5, 24'hFD8000, 1'b0, 18'h20000, 1'b1};
    tbl[5] = '{16'hFFFF, 1'b0, 5, 24'h04FFFB, 1'b0, 18'h3FFFF, 1'b1};
    tbl[6] = '{16'hFFFF, 1'b0, 4, 24'h03FFFC, 1'b0, 18'h3FFFC, 1'b0};
    tbl[7] = '{16'h8000, 1'b0, 1, 24'h008000, 1'b0, 18'h08000, 1'b0};
    tbl[8] = '{16'h8000, 1'b1, 1, 24'hFF8000, 1'b0, 18'h38000, 1'b0};

    Rst = 1'b1; Product = '0; Sign = 1'b0; In_Valid = 1'b0;
    In_Last = 1'b0; Clear = 1'b0; Out_Ready = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_res24", 32'(res24), 32'd0);
    chk("rst_ovf24", 32'(ovf24), 32'd0);
    chk("rst_ov24", 32'(ov24), 32'd0);
    chk("rst_rdy24", 32'(rdy24), 32'd1);
    Rst = 1'b0;
    step();

    for (int i = 0; i < 9; i++) begin
      string nm;
      nm = $sformatf("v%0d", i);
      send(nm, tbl[i].prod, tbl[i].sgn, tbl[i].n, 1'b1);
      check_out(nm, tbl[i].r24, tbl[i].o24, tbl[i].r18, tbl[i].o18);
      drain(nm);
    end

    // Sign on beat 2 must be ignored.
    beat(16'hFFFF, 1'b0, 1'b0);
    beat(16'hFFFF, 1'b1, 1'b1);
    check_out("sgn_tog", 24'h01FFFE, 1'b0, 18'h1FFFE, 1'b0);
    drain("sgn_tog");

    // Overflow stays set after later beats pull the sum back in.
    send("sticky", 16'h7FFF, 1'b1, 5, 1'b0);
    beat(16'h8000, 1'b1, 1'b1);
    check_out("sticky", 24'h01FFFB, 1'b0, 18'h17FFF, 1'b1);
    drain("sticky");

    // Downstream stall in HOLD with a beat offered.
    send("stall", 16'h0003, 1'b0, 2, 1'b1);
    check_out("stall", 24'h000006, 1'b0, 18'h00006, 1'b0);
    Product = 16'h1234; In_Valid = 1'b1; In_Last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("stall%0d_rdy", i), 32'(rdy24), 32'd0);
      chk($sformatf("stall%0d_ov", i), 32'(ov24), 32'd1);
      chk($sformatf("stall%0d_res", i), 32'(res24), 32'h6);
    end
    In_Valid = 1'b0; In_Last = 1'b0;
    drain("stall");
    chk("stall_res_after", 32'(res24), 32'h6);

    // Beat-count limit forces the end of the vector.
    send("maxlen", 16'h0001, 1'b0, 64, 1'b0);
    check_out("maxlen", 24'd64, 1'b0, 18'd64, 1'b0);
    drain("maxlen");

    // Clear on beat 3 of 5 aborts the vector.
    send("clr", 16'h0005, 1'b0, 2, 1'b0);
    Clear = 1'b1;
    beat(16'h0005, 1'b0, 1'b0);
    Clear = 1'b0;
    chk("clr_res", 32'(res24), 32'd0);
    chk("clr_ov", 32'(ov24), 32'd0);
    step();
    chk("clr_ov2", 32'(ov24), 32'd0);
    beat(16'h0002, 1'b0, 1'b1);
    check_out("clr_next", 24'd2, 1'b0, 18'd2, 1'b0);
    drain("clr_next");

    // Reset while a result is held.
    send("rsth", 16'h0007, 1'b1, 3, 1'b1);
    chk("rsth_pre_ov", 32'(ov24), 32'd1);
    Rst = 1'b1;
    #2;
    chk("rsth_ov", 32'(ov24), 32'd0);
    chk("rsth_res", 32'(res24), 32'd0);
    chk("rsth_ovf18", 32'(ovf18), 32'd0);
    chk("rsth_rdy", 32'(rdy24), 32'd1);
    Rst = 1'b0;
    step();
    chk("rsth_ov2", 32'(ov24), 32'd0);
    beat(16'h0002, 1'b0, 1'b1);
    check_out("rsth_next", 24'd2, 1'b0, 18'd2, 1'b0);
    drain("rsth_next");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 24: accumulator and Result width in bits, minimum 17.
REQ-002 SHALL have parameter MAX_LEN, default 64: maximum beats per vector; the MAX_LEN-th beat is treated as last.
REQ-003 SHALL have port Clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port Product, input, 16: product from the upstream 8x8 multiplier.
REQ-006 SHALL have port Sign, input, 1: 1 = signed (two's complement) operands, 0 = unsigned.
REQ-007 SHALL have port In_Valid, input, 1: Product, Sign and In_Last are valid.
REQ-008 SHALL have port In_Last, input, 1: the current beat is the final beat of a vector.
REQ-009 SHALL have port In_Ready, output, 1: the block accepts a beat this cycle.
REQ-010 SHALL have port Clear, input, 1: synchronous abort of the current vector.
REQ-011 SHALL have port Result, output, ACC_W: accumulated dot-product result.
REQ-012 SHALL have port Overflow, output, 1: saturation occurred in the vector now held in Result.
REQ-013 SHALL have port Out_Valid, output, 1: Result and Overflow are valid.
REQ-014 SHALL have port Out_Ready, input, 1: downstream accepts Result.

Function
REQ-015 SHALL implement a three-state FSM (IDLE, ACCUM, HOLD); In_Ready=1 in IDLE and ACCUM, 0 in HOLD; Out_Valid=1 only in HOLD.
REQ-016 A beat SHALL be accepted when In_Valid && In_Ready && !Clear.
REQ-017 On a beat accepted in IDLE, SHALL latch Sign for the whole vector, load acc=ext(Product), clear Overflow and set the beat count to 1.
REQ-018 On a beat accepted in ACCUM, SHALL use the latched sign, ignore the Sign input, set acc=sat(acc+ext(Product)) and increment the beat count.
REQ-019 ext() SHALL sign-extend Product to ACC_W when the latched sign is 1 and zero-extend it otherwise.
REQ-020 sat() SHALL clamp the result: signed to [-2^(ACC_W-1), 2^(ACC_W-1)-1], unsigned to [0, 2^ACC_W-1]; Overflow SHALL be set on any clamp and stay set until the next vector starts.
REQ-021 An accepted beat with In_Last=1, or one that brings the count to MAX_LEN, SHALL move the FSM to HOLD; otherwise IDLE SHALL go to ACCUM and ACCUM SHALL stay in ACCUM.
REQ-022 Out_Valid SHALL assert the cycle after the last beat is accepted (latency 1); a single-beat vector goes IDLE to HOLD directly.
REQ-023 In HOLD, Result and Overflow SHALL stay stable until Out_Valid && Out_Ready, after which the FSM SHALL go to IDLE.
REQ-024 Clear SHALL take precedence over beat acceptance and output handshake in every state: next state IDLE, acc=0, Overflow=0, count=0; a result held in HOLD is discarded.
REQ-025 Result SHALL equal acc in all states.

Reset
REQ-026 Rst=1 SHALL immediately force state IDLE, acc=0, Result=0, Overflow=0, Out_Valid=0, count=0 and the latched sign to 0; In_Ready SHALL be 1 after reset.
REQ-027 Rst asserted mid-vector or in HOLD SHALL discard all partial or held data without producing an output.

Structure
REQ-028 SHALL place the FSM state enum and the default ACC_W and MAX_LEN values in the shared package mac_pkg.
REQ-029 The extend/add/saturate datapath SHALL be a single sub-module, mac_sat_adder, which is purely combinational.

Verification
REQ-030 Signed, ACC_W=24: Product=0xFFFF x3 with Last on beat 3 -> Result=0xFFFFFD, Overflow=0, Out_Valid high exactly 1 cycle after beat 3.
REQ-031 Unsigned: Product=0xFFFF x2 with Last -> Result=0x01FFFE; Sign toggled on beat 2 is ignored.
REQ-032 ACC_W=18, signed: Product=0x7FFF x5 with Last -> Result=0x1FFFF, Overflow=1; the next vector with one beat of 0x0001 -> Result=1, Overflow=0.
REQ-033 Out_Ready held 0 for 5 cycles in HOLD -> In_Ready=0 and Result stable throughout; Out_Ready=1 -> IDLE next cycle.
REQ-034 MAX_LEN=64: 64 beats of 0x0001 with In_Last=0 -> Out_Valid, Result=64.
REQ-035 Clear on beat 3 of 5, and separately Rst asserted in HOLD -> no Out_Valid; the following 1-beat vector of 0x0002 -> Result=2.
